// File: rtl/n64adv_osd_wr_arbiter.sv
//------------------------------------------------------------------------------
// n64adv_osd_wr_arbiter
//
// Arbitrates writes into the OSD character buffer between the NIOS II
// requester (cpu_*) and the hardware info-line requester (hw_*), and
// optionally provides a clear engine that blanks the whole buffer.
//
// Build option:
//   N64ADV_OSD_CLR_ENGINE_EN  defined   -> clear engine present (IDLE/CLEAR FSM)
//                             undefined -> clr_req ignored, clr_busy/clr_done = 0
//
// Ports:
//   OSDCLK                 clock, all logic on rising edge
//   RST                    synchronous active-high reset
//   cpu_valid/ready/addr/data   NIOS II write requester (valid/ready handshake)
//   hw_valid/ready/addr/data    info-line write requester
//   clr_req                one-cycle pulse requesting a full buffer clear
//   clr_busy               high while a clear is in progress
//   clr_done               one-cycle pulse with the final clear write
//   wr_en/wr_addr/wr_data  registered buffer write port
//
// FSM (clear engine builds only):
//   state | meaning
//   IDLE  | arbitrate cpu/hw requesters, accept clr_req
//   CLEAR | write BLANK_WORD to 0..CLR_LAST, requesters stalled
//------------------------------------------------------------------------------
module n64adv_osd_wr_arbiter #(
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 12,
   parameter int CLR_LAST   = 1199,
   parameter int BLANK_WORD = 0
) (
   input  logic              OSDCLK,
   input  logic              RST,
   input  logic              cpu_valid,
   output logic              cpu_ready,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_data,
   input  logic              hw_valid,
   output logic              hw_ready,
   input  logic [ADDR_W-1:0] hw_addr,
   input  logic [DATA_W-1:0] hw_data,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data
);

   localparam logic [ADDR_W-1:0] ClrLastA = ADDR_W'(CLR_LAST);
   localparam logic [DATA_W-1:0] BlankW   = DATA_W'(BLANK_WORD);

   logic              inClear;   // state is CLEAR
   logic              clrStart;  // clr_req accepted this cycle
   logic [ADDR_W-1:0] clrCnt;
   logic              hwLast;    // round-robin pointer: 1 = hw won last transfer
   logic              cpuXfer;
   logic              hwXfer;

`ifdef N64ADV_OSD_CLR_ENGINE_EN
   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   state_t state, stateNext;
   logic   clrLast;

   always_ff @(posedge OSDCLK) begin
      if (RST) state <= IDLE;
      else     state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (clr_req) stateNext = CLEAR;
         CLEAR:   if (clrLast) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   assign inClear  = (state == CLEAR);
   assign clrStart = (state == IDLE) && clr_req;
   assign clrLast  = inClear && (clrCnt == ClrLastA);

   // clr_busy is registered so it stays high through the cycle that carries
   // the final clear write, which is already back in IDLE.
   always_ff @(posedge OSDCLK) begin
      if (RST) begin
         clrCnt   <= '0;
         clr_busy <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         clr_busy <= clrStart || inClear;
         clr_done <= clrLast;
         if (clrStart)     clrCnt <= '0;
         else if (inClear) clrCnt <= clrCnt + 1'b1;
      end
   end
`else
   logic unusedClrReq;

   assign unusedClrReq = clr_req;
   assign inClear      = 1'b0;
   assign clrStart     = 1'b0;
   assign clrCnt       = '0;
   assign clr_busy     = 1'b0;
   assign clr_done     = 1'b0;
`endif

   // Ready generation; a clear request in IDLE pre-empts both requesters.
   always_comb begin
      cpu_ready = 1'b0;
      hw_ready  = 1'b0;
      if (!RST && !inClear && !clrStart) begin
         if (cpu_valid && (!hw_valid || hwLast)) cpu_ready = 1'b1;
         else if (hw_valid)                      hw_ready  = 1'b1;
      end
   end

   assign cpuXfer = cpu_valid && cpu_ready;
   assign hwXfer  = hw_valid && hw_ready;

   // Registered write port; address/data hold when nothing is written.
   always_ff @(posedge OSDCLK) begin
      if (RST) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         hwLast  <= 1'b1;
      end else begin
         wr_en <= 1'b0;
         if (inClear) begin
            wr_en   <= 1'b1;
            wr_addr <= clrCnt;
            wr_data <= BlankW;
         end else if (cpuXfer) begin
            wr_en   <= 1'b1;
            wr_addr <= cpu_addr;
            wr_data <= cpu_data;
            hwLast  <= 1'b0;
         end else if (hwXfer) begin
            wr_en   <= 1'b1;
            wr_addr <= hw_addr;
            wr_data <= hw_data;
            hwLast  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_n64adv_osd_wr_arbiter.sv
module tb_n64adv_osd_wr_arbiter;

   localparam int ADDR_W   = 11;
   localparam int DATA_W   = 12;
   localparam int CLR_LAST = 1199;
   localparam int BLANK    = 12'h020;
`ifdef N64ADV_OSD_CLR_ENGINE_EN
   localparam bit CLR_EN = 1'b1;
`else
   localparam bit CLR_EN = 1'b0;
`endif

   logic              OSDCLK = 1'b0;
   logic              RST;
   logic              cpu_valid, cpu_ready, hw_valid, hw_ready;
   logic [ADDR_W-1:0] cpu_addr, hw_addr, wr_addr;
   logic [DATA_W-1:0] cpu_data, hw_data, wr_data;
   logic              clr_req, clr_busy, clr_done, wr_en;

   n64adv_osd_wr_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLR_LAST(CLR_LAST), .BLANK_WORD(BLANK)
   ) dut (
      .OSDCLK(OSDCLK), .RST(RST),
      .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
      .hw_valid(hw_valid), .hw_ready(hw_ready), .hw_addr(hw_addr), .hw_data(hw_data),
      .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 OSDCLK = ~OSDCLK;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // The model tracks how many clear writes remain; while any remain the
   // buffer belongs to the clear, otherwise the requesters share it
   // round-robin. Expected write-port values are one cycle behind.
   bit                chkOn = 1'b0;
   int                mClrLeft = 0;
   bit                mHwLast = 1'b1;
   bit                eWrEn = 1'b0, eBusy = 1'b0, eDone = 1'b0;
   logic [ADDR_W-1:0] eWrAddr = '0;
   logic [DATA_W-1:0] eWrData = '0;

   // observations for the literal checks
   int                clrWrites = 0, doneCount = 0;
   logic [ADDR_W-1:0] doneAddr = '0;
   logic [ADDR_W-1:0] logAddr[$];
   logic [DATA_W-1:0] logData[$];

   always @(negedge OSDCLK) begin
      if (chkOn) begin
         int g;   // 0 none, 1 cpu, 2 hw
         g = 0;
         if (!RST && mClrLeft == 0 && !(CLR_EN && clr_req)) begin
            if (cpu_valid && hw_valid) g = mHwLast ? 1 : 2;
            else if (cpu_valid)        g = 1;
            else if (hw_valid)         g = 2;
         end
         chk("cpu_ready", 32'(cpu_ready), 32'(g == 1));
         chk("hw_ready",  32'(hw_ready),  32'(g == 2));
         chk("wr_en",     32'(wr_en),     32'(eWrEn));
         chk("wr_addr",   32'(wr_addr),   32'(eWrAddr));
         chk("wr_data",   32'(wr_data),   32'(eWrData));
         chk("clr_busy",  32'(clr_busy),  32'(eBusy));
         chk("clr_done",  32'(clr_done),  32'(eDone));

         if (wr_en === 1'b1) begin
            logAddr.push_back(wr_addr);
            logData.push_back(wr_data);
            if (wr_data == DATA_W'(BLANK)) clrWrites++;
         end
         if (clr_done === 1'b1) begin
            doneCount++;
            doneAddr = wr_addr;
         end

         if (RST) begin
            mClrLeft = 0; mHwLast = 1'b1;
            eWrEn = 0; eWrAddr = '0; eWrData = '0; eBusy = 0; eDone = 0;
         end else if (mClrLeft > 0) begin
            eWrEn   = 1;
            eWrAddr = ADDR_W'(CLR_LAST + 1 - mClrLeft);
            eWrData = DATA_W'(BLANK);
            eDone   = (mClrLeft == 1);
            eBusy   = 1;
            mClrLeft--;
         end else if (CLR_EN && clr_req) begin
            eWrEn = 0; eBusy = 1; eDone = 0;
            mClrLeft = CLR_LAST + 1;
         end else begin
            eWrEn = 0; eBusy = 0; eDone = 0;
            if (g == 1) begin
               eWrEn = 1; eWrAddr = cpu_addr; eWrData = cpu_data; mHwLast = 0;
            end else if (g == 2) begin
               eWrEn = 1; eWrAddr = hw_addr; eWrData = hw_data; mHwLast = 1;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge OSDCLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      step();
      RST = 1'b0;
   endtask

   logic [3:0] grants;
   int         waited;
   int         doneBefore;

   initial begin
      RST = 1'b1; clr_req = 0;
      cpu_valid = 0; cpu_addr = '0; cpu_data = '0;
      hw_valid = 0;  hw_addr = '0;  hw_data = '0;
      step();
      chkOn = 1'b1;
      step();
      RST = 1'b0;
      chk("rst_wr_en",    32'(wr_en),    0);
      chk("rst_wr_addr",  32'(wr_addr),  0);
      chk("rst_clr_busy", 32'(clr_busy), 0);

      // single cpu request
      cpu_valid = 1; cpu_addr = 11'h010; cpu_data = 12'h0A5;
      #2 chk("single_cpu_ready", 32'(cpu_ready), 1);
      step();
      cpu_valid = 0;
      chk("single_wr_en",   32'(wr_en),   1);
      chk("single_wr_addr", 32'(wr_addr), 32'h010);
      chk("single_wr_data", 32'(wr_data), 32'h0A5);
      step();

      // round-robin from reset: cpu, hw, cpu, hw
      do_reset();
      logAddr.delete(); logData.delete();
      cpu_valid = 1; hw_valid = 1;
      cpu_addr = 11'h100; cpu_data = 12'h111; hw_addr = 11'h200; hw_data = 12'h222;
      #2 grants[0] = cpu_ready; step();
      cpu_addr = 11'h101; cpu_data = 12'h112;
      #2 grants[1] = cpu_ready; step();
      hw_addr = 11'h201; hw_data = 12'h223;
      #2 grants[2] = cpu_ready; step();
      cpu_addr = 11'h102; cpu_data = 12'h113;
      #2 grants[3] = cpu_ready; step();
      cpu_valid = 0; hw_valid = 0;
      step();
      chk("rr_grants", 32'(grants), 32'b0101);
      chk("rr_nwrites", 32'(logAddr.size()), 4);
      if (logAddr.size() == 4) begin
         chk("rr_w0", {logAddr[0], logData[0]}, {11'h100, 12'h111});
         chk("rr_w1", {logAddr[1], logData[1]}, {11'h200, 12'h222});
         chk("rr_w2", {logAddr[2], logData[2]}, {11'h101, 12'h112});
         chk("rr_w3", {logAddr[3], logData[3]}, {11'h201, 12'h223});
      end

      // clear with a simultaneous cpu request
      clrWrites = 0; doneCount = 0;
      logAddr.delete(); logData.delete();
      clr_req = 1; cpu_valid = 1; cpu_addr = 11'h321; cpu_data = 12'h456;
      #2 chk("clr_pre_cpu_ready", 32'(cpu_ready), 32'(!CLR_EN));
      waited = 0;
      while (cpu_ready !== 1'b1 && waited < 1400) begin
         step();
         clr_req = 0;
         waited++;
         #2;
      end
      chk("clr_wait_cycles", 32'(waited), CLR_EN ? 1201 : 0);
      step();
      clr_req = 0; cpu_valid = 0;
      chk("clr_cpu_wr_addr", 32'(wr_addr), 32'h321);
      chk("clr_cpu_wr_data", 32'(wr_data), 32'h456);
      step();
      chk("clr_writes", 32'(clrWrites), CLR_EN ? 1200 : 0);
      chk("clr_done_count", 32'(doneCount), CLR_EN ? 1 : 0);
      if (CLR_EN) chk("clr_done_addr", 32'(doneAddr), CLR_LAST);
      if (CLR_EN && logAddr.size() > 1)
         chk("clr_last_addr", 32'(logAddr[logAddr.size()-2]), CLR_LAST);

      // reset in the middle of a clear
      clr_req = 1;
      step();
      clr_req = 0;
      repeat (501) step();
      if (CLR_EN) chk("abort_at_addr", 32'(wr_addr), 500);
      doneBefore = doneCount;
      RST = 1;
      step();
      RST = 0;
      chk("abort_wr_en",    32'(wr_en),    0);
      chk("abort_clr_busy", 32'(clr_busy), 0);
      repeat (10) step();
      chk("abort_no_done", 32'(doneCount - doneBefore), 0);
      cpu_valid = 1; cpu_addr = 11'h055; cpu_data = 12'h0AA;
      #2 chk("abort_idle_ready", 32'(cpu_ready), 1);
      step();
      cpu_valid = 0;
      chk("abort_cpu_wr", {wr_en, wr_addr, wr_data}, {1'b1, 11'h055, 12'h0AA});

      // hw-only request and a withdrawn request
      hw_valid = 1; hw_addr = 11'h7FF; hw_data = 12'hFFF;
      step();
      hw_valid = 0;
      chk("hw_only_wr", {wr_en, wr_addr, wr_data}, {1'b1, 11'h7FF, 12'hFFF});
      step();
      chk("idle_hold", {wr_en, wr_addr, wr_data}, {1'b0, 11'h7FF, 12'hFFF});
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
